// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: command encodings, FSM states and a
// small sizing helper used to dimension the shared cycle counter.
package spi_pkg;

   typedef enum logic [1:0] {
      CMD_WR_ADDR = 2'b00,
      CMD_WR_DATA = 2'b01,
      CMD_RD_ADDR = 2'b10,
      CMD_RD_DATA = 2'b11
   } spi_cmd_e;

   typedef enum logic [2:0] {
      IDLE,
      START,
      SHIFT,
      WAIT,
      RECV,
      RESP,
      GAP
   } spi_state_e;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // A phase of n cycles loads the counter with n-1; zero-length phases are skipped.
   function automatic int phase_init(input int cycles);
      return (cycles > 0) ? cycles - 1 : 0;
   endfunction

endpackage

// File: rtl/spi_master_shifter.sv
// Datapath of the SPI master: parallel-in/serial-out frame register for MOSI,
// serial-in/parallel-out register for MISO and the down-counter timing each phase.
module spi_master_shifter
   import spi_pkg::*;
#(
   parameter int FRAME_W = 10,
   parameter int WORD_W  = 8,
   parameter int CNT_W   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [FRAME_W-1:0] frame_in,
   input  logic               tx_shift,
   input  logic               rx_shift,
   input  logic               miso,
   input  logic               cnt_load,
   input  logic [CNT_W-1:0]   cnt_init,
   output logic               tx_msb,
   output logic               tx_next,
   output logic [WORD_W-1:0]  rx_word,
   output logic               cnt_zero
);

   logic [FRAME_W-1:0] tx_q, tx_d;
   logic [WORD_W-2:0]  rx_q, rx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   // rx_word already includes the bit on MISO now, so the final sample can be
   // captured straight into the response register without an extra cycle.
   assign rx_word  = {rx_q, miso};
   assign tx_msb   = tx_q[FRAME_W-1];
   assign tx_next  = tx_q[FRAME_W-2];
   assign cnt_zero = (cnt_q == '0);

   always_comb begin
      tx_d  = tx_q;
      rx_d  = rx_q;
      cnt_d = cnt_q;
      if (load) begin
         tx_d = frame_in;
      end else if (tx_shift) begin
         tx_d = {tx_q[FRAME_W-2:0], 1'b0};
      end
      if (rx_shift) begin
         rx_d = rx_word[WORD_W-2:0];
      end
      if (cnt_load) begin
         cnt_d = cnt_init;
      end else if (!cnt_zero) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_q  <= '0;
         rx_q  <= '0;
         cnt_q <= '0;
      end else begin
         tx_q  <= tx_d;
         rx_q  <= rx_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/spi_master_interface.sv
// SPI master: sends {cmd,payload} frames MSB first and, for read-data commands,
// collects one word from MISO. Optional macro SPI_MASTER_SEQ_CHECK_EN adds a sticky command-order check.
module spi_master_interface
   import spi_pkg::*;
#(
   parameter int MEM_INPUT_SIZE = 10,
   parameter int MEM_WORD_SIZE  = 8,
   parameter int READ_WAIT      = 2,
   parameter int GAP_CYCLES     = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [1:0]               req_cmd,
   input  logic [MEM_WORD_SIZE-1:0] req_data,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [MEM_WORD_SIZE-1:0] rsp_data,
   output logic                     SS_n,
   output logic                     MOSI,
   input  logic                     MISO,
   output logic                     busy,
   output logic                     seq_err
);

   localparam int CNT_MAX = max_of(max_of(MEM_INPUT_SIZE, MEM_WORD_SIZE),
                                   max_of(READ_WAIT, GAP_CYCLES));
   localparam int CNT_W   = max_of($clog2(CNT_MAX + 1), 1);

   localparam logic [CNT_W-1:0] SHIFT_INIT = CNT_W'(phase_init(MEM_INPUT_SIZE));
   localparam logic [CNT_W-1:0] WAIT_INIT  = CNT_W'(phase_init(READ_WAIT));
   localparam logic [CNT_W-1:0] RECV_INIT  = CNT_W'(phase_init(MEM_WORD_SIZE));
   localparam logic [CNT_W-1:0] GAP_INIT   = CNT_W'(phase_init(GAP_CYCLES));

   spi_state_e               state_q, state_d;
   spi_cmd_e                 cmd_q, cmd_d;
   logic                     ss_n_q, ss_n_d;
   logic                     mosi_q, mosi_d;
   logic                     rsp_valid_q, rsp_valid_d;
   logic [MEM_WORD_SIZE-1:0] rsp_data_q, rsp_data_d;

   logic                     accept;
   logic                     load, tx_shift, rx_shift, cnt_load, cnt_zero;
   logic                     tx_msb, tx_next;
   logic [CNT_W-1:0]         cnt_init;
   logic [MEM_WORD_SIZE-1:0] rx_word;

   assign req_ready = (state_q == IDLE) && !rsp_valid_q;
   assign accept    = req_valid && req_ready;
   assign busy      = (state_q != IDLE);
   assign SS_n      = ss_n_q;
   assign MOSI      = mosi_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;

   spi_master_shifter #(
      .FRAME_W (MEM_INPUT_SIZE),
      .WORD_W  (MEM_WORD_SIZE),
      .CNT_W   (CNT_W)
   ) u_shifter (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .frame_in ({req_cmd, req_data}),
      .tx_shift (tx_shift),
      .rx_shift (rx_shift),
      .miso     (MISO),
      .cnt_load (cnt_load),
      .cnt_init (cnt_init),
      .tx_msb   (tx_msb),
      .tx_next  (tx_next),
      .rx_word  (rx_word),
      .cnt_zero (cnt_zero)
   );

   // Outputs are computed for the state being entered, so SS_n/MOSI change
   // on the same edge as the state register.
   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      ss_n_d      = ss_n_q;
      mosi_d      = mosi_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      load        = 1'b0;
      tx_shift    = 1'b0;
      rx_shift    = 1'b0;
      cnt_load    = 1'b0;
      cnt_init    = '0;

      unique case (state_q)
         IDLE: begin
            ss_n_d = 1'b1;
            mosi_d = 1'b0;
            if (accept) begin
               load    = 1'b1;
               cmd_d   = spi_cmd_e'(req_cmd);
               state_d = START;
               ss_n_d  = 1'b0;
               mosi_d  = req_cmd[1];
            end
         end
         START: begin
            state_d  = SHIFT;
            cnt_load = 1'b1;
            cnt_init = SHIFT_INIT;
            mosi_d   = tx_msb;
         end
         SHIFT: begin
            if (!cnt_zero) begin
               tx_shift = 1'b1;
               mosi_d   = tx_next;
            end else if (cmd_q == CMD_RD_DATA) begin
               mosi_d   = 1'b0;
               cnt_load = 1'b1;
               if (READ_WAIT > 0) begin
                  state_d  = WAIT;
                  cnt_init = WAIT_INIT;
               end else begin
                  state_d  = RECV;
                  cnt_init = RECV_INIT;
               end
            end else begin
               ss_n_d   = 1'b1;
               mosi_d   = 1'b0;
               cnt_load = 1'b1;
               cnt_init = GAP_INIT;
               state_d  = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
         end
         WAIT: begin
            if (cnt_zero) begin
               state_d  = RECV;
               cnt_load = 1'b1;
               cnt_init = RECV_INIT;
            end
         end
         RECV: begin
            rx_shift = 1'b1;
            if (cnt_zero) begin
               state_d     = RESP;
               rsp_data_d  = rx_word;
               rsp_valid_d = 1'b1;
               ss_n_d      = 1'b1;
               mosi_d      = 1'b0;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               cnt_load    = 1'b1;
               cnt_init    = GAP_INIT;
               state_d     = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
         end
         GAP: begin
            if (cnt_zero) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            ss_n_d  = 1'b1;
            mosi_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cmd_q       <= CMD_WR_ADDR;
         ss_n_q      <= 1'b1;
         mosi_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         ss_n_q      <= ss_n_d;
         mosi_q      <= mosi_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

`ifdef SPI_MASTER_SEQ_CHECK_EN
   spi_cmd_e last_cmd_q, last_cmd_d;
   logic     last_valid_q, last_valid_d;
   logic     seq_err_q, seq_err_d;

   // Data commands must follow their address command; nothing accepted since
   // reset counts as having no valid predecessor.
   always_comb begin
      last_cmd_d   = last_cmd_q;
      last_valid_d = last_valid_q;
      seq_err_d    = seq_err_q;
      if (accept) begin
         if ((req_cmd == CMD_WR_DATA) &&
             !(last_valid_q && ((last_cmd_q == CMD_WR_ADDR) || (last_cmd_q == CMD_WR_DATA)))) begin
            seq_err_d = 1'b1;
         end
         if ((req_cmd == CMD_RD_DATA) && !(last_valid_q && (last_cmd_q == CMD_RD_ADDR))) begin
            seq_err_d = 1'b1;
         end
         last_cmd_d   = spi_cmd_e'(req_cmd);
         last_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_cmd_q   <= CMD_WR_ADDR;
         last_valid_q <= 1'b0;
         seq_err_q    <= 1'b0;
      end else begin
         last_cmd_q   <= last_cmd_d;
         last_valid_q <= last_valid_d;
         seq_err_q    <= seq_err_d;
      end
   end

   assign seq_err = seq_err_q;
`else
   assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_interface.sv
// Self-checking bench for spi_master_interface: directed scenarios plus random
// frames checked against a frame-level model that also plays the SPI slave.
module tb_spi_master_interface;

   localparam int FS = 10;
   localparam int WS = 8;
   localparam int RW = 2;
   localparam int GC = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [1:0]    req_cmd;
   logic [WS-1:0] req_data;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [WS-1:0] rsp_data;
   logic          SS_n;
   logic          MOSI;
   logic          MISO;
   logic          busy;
   logic          seq_err;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Reference model state: slave memory, address pointers, last response, order tracking.
   logic [7:0] mem [256];
   logic [7:0] wr_addr, rd_addr, last_rsp;
   logic [1:0] last_cmd;
   bit         have_last, seq_exp;
   int         rise_cyc, fall_cyc, low_gap;

   spi_master_interface #(
      .MEM_INPUT_SIZE (FS),
      .MEM_WORD_SIZE  (WS),
      .READ_WAIT      (RW),
      .GAP_CYCLES     (GC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_cmd   (req_cmd),
      .req_data  (req_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .SS_n      (SS_n),
      .MOSI      (MOSI),
      .MISO      (MISO),
      .busy      (busy),
      .seq_err   (seq_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      have_last = 1'b0;
      seq_exp   = 1'b0;
      last_rsp  = 8'h00;
   endtask

   task automatic modelAccept(input logic [1:0] cmd, input logic [7:0] data);
`ifdef SPI_MASTER_SEQ_CHECK_EN
      if (cmd == 2'b01 && !(have_last && (last_cmd == 2'b00 || last_cmd == 2'b01))) seq_exp = 1'b1;
      if (cmd == 2'b11 && !(have_last && last_cmd == 2'b10)) seq_exp = 1'b1;
`endif
      last_cmd  = cmd;
      have_last = 1'b1;
      case (cmd)
         2'b00:   wr_addr = data;
         2'b01:   mem[wr_addr] = data;
         2'b10:   rd_addr = data;
         default: ;
      endcase
   endtask

   // One complete frame from IDLE back to IDLE, checked cycle by cycle.
   task automatic applyStimulus(input logic [1:0] cmd, input logic [7:0] data,
                                input int hold, input bit keep_valid);
      logic [FS-1:0] frame;
      logic [7:0]    rbyte;
      bit            is_read;
      int            low, recv_start, waited;
      frame      = {cmd, data};
      is_read    = (cmd == 2'b11);
      rbyte      = mem[rd_addr];
      low        = 1 + FS + (is_read ? RW + WS : 0);
      recv_start = 1 + FS + RW;
      req_valid  = 1'b1;
      req_cmd    = cmd;
      req_data   = data;
      waited     = 0;
      while (req_ready !== 1'b1 && waited < 50) begin
         tick();
         waited++;
      end
      checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
      tick();
      if (!keep_valid) req_valid = 1'b0;
      modelAccept(cmd, data);
      fall_cyc = cyc;
      low_gap  = fall_cyc - rise_cyc;
      for (int k = 0; k < low; k++) begin
         checkOutput("ss_n_low", 32'(SS_n), 32'd0);
         checkOutput("busy_frame", 32'(busy), 32'd1);
         checkOutput("rsp_valid_frame", 32'(rsp_valid), 32'd0);
         if (k == 0) checkOutput("mosi_start", 32'(MOSI), 32'(frame[FS-1]));
         else if (k <= FS) checkOutput("mosi_bit", 32'(MOSI), 32'(frame[FS-k]));
         else if (k < recv_start) checkOutput("mosi_wait", 32'(MOSI), 32'd0);
         if (is_read && k >= recv_start) MISO = rbyte[WS-1-(k-recv_start)];
         else MISO = 1'($urandom);
         tick();
      end
      rise_cyc = cyc;
      if (is_read) begin
         for (int h = 0; h <= hold; h++) begin
            checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("rsp_data", 32'(rsp_data), 32'(rbyte));
            checkOutput("ss_n_resp", 32'(SS_n), 32'd1);
            checkOutput("req_ready_resp", 32'(req_ready), 32'd0);
            if (h == hold) rsp_ready = 1'b1;
            tick();
         end
         rsp_ready = 1'b0;
         last_rsp  = rbyte;
      end
      for (int g = 0; g < GC; g++) begin
         checkOutput("ss_n_gap", 32'(SS_n), 32'd1);
         checkOutput("mosi_gap", 32'(MOSI), 32'd0);
         checkOutput("busy_gap", 32'(busy), 32'd1);
         checkOutput("rsp_valid_gap", 32'(rsp_valid), 32'd0);
         tick();
      end
      checkOutput("busy_idle", 32'(busy), 32'd0);
      checkOutput("req_ready_back", 32'(req_ready), 32'd1);
      checkOutput("rsp_data_hold", 32'(rsp_data), 32'(last_rsp));
      checkOutput("seq_err", 32'(seq_err), 32'(seq_exp));
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_cmd   = 2'b00;
      req_data  = '0;
      rsp_ready = 1'b0;
      MISO      = 1'b0;
      wr_addr   = 8'h00;
      rd_addr   = 8'h00;
      last_cmd  = 2'b00;
      rise_cyc  = 0;
      fall_cyc  = 0;
      low_gap   = 0;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      modelReset();
      repeat (2) tick();
      checkOutput("rst_ss_n", 32'(SS_n), 32'd1);
      checkOutput("rst_mosi", 32'(MOSI), 32'd0);
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_seq_err", 32'(seq_err), 32'd0);
      rst = 1'b0;
      tick();
      checkOutput("req_ready_after_rst", 32'(req_ready), 32'd1);

      applyStimulus(2'b00, 8'h01, 0, 1'b0);

      applyStimulus(2'b01, 8'h8A, 0, 1'b0);
      applyStimulus(2'b10, 8'h01, 0, 1'b0);
      applyStimulus(2'b11, 8'h00, 0, 1'b0);
      checkOutput("e2e_rsp_data", 32'(rsp_data), 32'h8A);

      applyStimulus(2'b10, 8'($urandom), 0, 1'b0);
      applyStimulus(2'b11, 8'h00, 5, 1'b0);

      applyStimulus(2'b00, 8'($urandom), 0, 1'b1);
      applyStimulus(2'b01, 8'($urandom), 0, 1'b0);
      checkOutput("b2b_ss_n_gap", 32'(low_gap), 32'(GC + 1));

      for (int n = 0; n < 24; n++) begin
         applyStimulus(2'($urandom_range(0, 3)), 8'($urandom), int'($urandom_range(0, 3)), 1'b0);
      end

      req_valid = 1'b1;
      req_cmd   = 2'b11;
      req_data  = 8'h00;
      tick();
      req_valid = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      checkOutput("midrst_ss_n", 32'(SS_n), 32'd1);
      checkOutput("midrst_mosi", 32'(MOSI), 32'd0);
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      rst = 1'b0;
      modelReset();
      tick();
      checkOutput("midrst_req_ready", 32'(req_ready), 32'd1);
      for (int i = 0; i < 30; i++) begin
         checkOutput("midrst_no_rsp", 32'(rsp_valid), 32'd0);
         checkOutput("midrst_ss_high", 32'(SS_n), 32'd1);
         tick();
      end

      rst = 1'b1;
      tick();
      rst = 1'b0;
      modelReset();
      tick();
      applyStimulus(2'b11, 8'h00, 0, 1'b0);
`ifdef SPI_MASTER_SEQ_CHECK_EN
      checkOutput("seq_err_rd_first", 32'(seq_err), 32'd1);
`else
      checkOutput("seq_err_rd_first", 32'(seq_err), 32'd0);
`endif
      applyStimulus(2'b00, 8'($urandom), 0, 1'b0);
      applyStimulus(2'b01, 8'($urandom), 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
